// File: rtl/axis_eth_tx_framer.sv
// Ethernet TX framer: AXI-Stream bytes in, GMII-style bytes out with preamble/SFD,
// zero padding, CRC-32 FCS and inter-frame gap; ce_i sets the byte-slot rate.
module axis_eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int IFG_LEN      = 12,
    parameter bit PAD_EN       = 1'b1,
    parameter bit CRC_EN       = 1'b1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           gmii_txd,
    output logic                 gmii_tx_en,
    output logic                 gmii_tx_er,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] frame_cnt_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    localparam int SLOT_W = 16;
    localparam int BC_W   = (MIN_PAYLOAD < 1) ? 1 : $clog2(MIN_PAYLOAD + 1);

    localparam logic [SLOT_W-1:0] PRE_LAST  = SLOT_W'(PREAMBLE_LEN - 1);
    localparam logic [SLOT_W-1:0] IFG_LAST  = SLOT_W'(IFG_LEN - 1);
    localparam logic [BC_W-1:0]   BC_MAX    = BC_W'(MIN_PAYLOAD);
    localparam logic [31:0]       CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0]       CRC_POLY  = 32'hEDB8_8320;
    localparam logic [7:0]        PRE_BYTE  = 8'h55;
    localparam logic [7:0]        SFD_BYTE  = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } state_t;

    state_t               state, state_n;
    logic [31:0]          crc, crc_n;
    logic [BC_W-1:0]      byte_cnt, byte_cnt_n, bc_inc;
    logic [SLOT_W-1:0]    slot_cnt, slot_cnt_n;
    logic [7:0]           txd_n;
    logic                 tx_en_n, tx_er_n;
    logic [CNT_WIDTH-1:0] frame_cnt_n, err_cnt_n;
    logic [31:0]          fcs;

    // Reflected CRC-32, one byte per call, LSB of the byte processed first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // tready is combinational so that it tracks ce_i within the same clock.
    assign s_axis_tready = ce_i && !rst_i && (state == ST_DATA || state == ST_DRAIN);
    assign busy_o        = (state != ST_IDLE);

    always_comb begin
        state_n     = state;
        crc_n       = crc;
        byte_cnt_n  = byte_cnt;
        slot_cnt_n  = slot_cnt;
        txd_n       = 8'h00;
        tx_en_n     = 1'b0;
        tx_er_n     = 1'b0;
        frame_cnt_n = frame_cnt_o;
        err_cnt_n   = err_cnt_o;
        fcs         = ~crc;
        bc_inc      = (byte_cnt == BC_MAX) ? byte_cnt : byte_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                crc_n      = CRC_INIT;
                byte_cnt_n = '0;
                slot_cnt_n = '0;
                if (s_axis_tvalid) begin
                    txd_n      = PRE_BYTE;
                    tx_en_n    = 1'b1;
                    slot_cnt_n = SLOT_W'(1);
                    state_n    = (PREAMBLE_LEN == 1) ? ST_SFD : ST_PRE;
                end
            end
            ST_PRE: begin
                txd_n      = PRE_BYTE;
                tx_en_n    = 1'b1;
                slot_cnt_n = slot_cnt + 1'b1;
                if (slot_cnt >= PRE_LAST) begin
                    state_n = ST_SFD;
                end
            end
            ST_SFD: begin
                txd_n   = SFD_BYTE;
                tx_en_n = 1'b1;
                state_n = ST_DATA;
            end
            ST_DATA: begin
                tx_en_n = 1'b1;
                if (s_axis_tvalid) begin
                    txd_n      = s_axis_tdata;
                    crc_n      = crc_byte(crc, s_axis_tdata);
                    byte_cnt_n = bc_inc;
                    if (s_axis_tlast) begin
                        slot_cnt_n = '0;
                        if (s_axis_tuser) begin
                            tx_er_n   = 1'b1;
                            err_cnt_n = err_cnt_o + 1'b1;
                            state_n   = ST_IFG;
                        end else if (PAD_EN && (bc_inc < BC_MAX)) begin
                            state_n = ST_PAD;
                        end else if (CRC_EN) begin
                            state_n = ST_FCS;
                        end else begin
                            frame_cnt_n = frame_cnt_o + 1'b1;
                            state_n     = ST_IFG;
                        end
                    end
                end else begin
                    // Source ran dry mid-frame: poison this slot and discard the rest.
                    tx_er_n   = 1'b1;
                    err_cnt_n = err_cnt_o + 1'b1;
                    state_n   = ST_DRAIN;
                end
            end
            ST_PAD: begin
                tx_en_n    = 1'b1;
                crc_n      = crc_byte(crc, 8'h00);
                byte_cnt_n = bc_inc;
                if (bc_inc == BC_MAX) begin
                    slot_cnt_n = '0;
                    if (CRC_EN) begin
                        state_n = ST_FCS;
                    end else begin
                        frame_cnt_n = frame_cnt_o + 1'b1;
                        state_n     = ST_IFG;
                    end
                end
            end
            ST_FCS: begin
                tx_en_n = 1'b1;
                case (slot_cnt[1:0])
                    2'd0:    txd_n = fcs[7:0];
                    2'd1:    txd_n = fcs[15:8];
                    2'd2:    txd_n = fcs[23:16];
                    default: txd_n = fcs[31:24];
                endcase
                if (slot_cnt[1:0] == 2'd3) begin
                    slot_cnt_n  = '0;
                    frame_cnt_n = frame_cnt_o + 1'b1;
                    state_n     = ST_IFG;
                end else begin
                    slot_cnt_n = slot_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    slot_cnt_n = '0;
                    state_n    = ST_IFG;
                end
            end
            ST_IFG: begin
                if (slot_cnt >= IFG_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    slot_cnt_n = slot_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Everything advances only on an enabled byte slot; ce_i=0 freezes the outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            crc         <= CRC_INIT;
            byte_cnt    <= '0;
            slot_cnt    <= '0;
            gmii_txd    <= 8'h00;
            gmii_tx_en  <= 1'b0;
            gmii_tx_er  <= 1'b0;
            frame_cnt_o <= '0;
            err_cnt_o   <= '0;
        end else if (ce_i) begin
            state       <= state_n;
            crc         <= crc_n;
            byte_cnt    <= byte_cnt_n;
            slot_cnt    <= slot_cnt_n;
            gmii_txd    <= txd_n;
            gmii_tx_en  <= tx_en_n;
            gmii_tx_er  <= tx_er_n;
            frame_cnt_o <= frame_cnt_n;
            err_cnt_o   <= err_cnt_n;
        end
    end

endmodule

// File: tb/tb_axis_eth_tx_framer.sv
// Directed bench for axis_eth_tx_framer: one default instance and one with padding off,
// sharing stimulus; every test captures the GMII stream and compares it to expected bytes.
module tb_axis_eth_tx_framer;

    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ce, tvalid, tlast, tuser;
    logic [7:0]    tdata;
    logic          tready_a, tx_en_a, tx_er_a, busy_a;
    logic [7:0]    txd_a;
    logic [CW-1:0] fc_a, ec_a;
    logic          tready_b, tx_en_b, tx_er_b, busy_b;
    logic [7:0]    txd_b;
    logic [CW-1:0] fc_b, ec_b;

    logic          use_np, ce_toggle;
    logic          sel_tready, sel_en, sel_er, sel_busy;
    logic [7:0]    sel_txd;
    logic [CW-1:0] sel_fc, sel_ec;

    assign sel_tready = use_np ? tready_b : tready_a;
    assign sel_en     = use_np ? tx_en_b  : tx_en_a;
    assign sel_er     = use_np ? tx_er_b  : tx_er_a;
    assign sel_busy   = use_np ? busy_b   : busy_a;
    assign sel_txd    = use_np ? txd_b    : txd_a;
    assign sel_fc     = use_np ? fc_b     : fc_a;
    assign sel_ec     = use_np ? ec_b     : ec_a;

    axis_eth_tx_framer #(.CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_a),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .gmii_txd(txd_a), .gmii_tx_en(tx_en_a), .gmii_tx_er(tx_er_a),
        .busy_o(busy_a), .frame_cnt_o(fc_a), .err_cnt_o(ec_a)
    );

    axis_eth_tx_framer #(.PAD_EN(1'b0), .CNT_WIDTH(CW)) dut_np (
        .clk_i(clk), .rst_i(rst), .ce_i(ce),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_b),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .gmii_txd(txd_b), .gmii_tx_en(tx_en_b), .gmii_tx_er(tx_er_b),
        .busy_o(busy_b), .frame_cnt_o(fc_b), .err_cnt_o(ec_b)
    );

    int         checks, errors, tready_bad;
    logic [7:0] cap_d[$];
    logic       cap_en[$];
    logic       cap_er[$];
    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];
    logic       last_q[$];
    logic       user_q[$];

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // One clock: capture outputs at negedge, advance, then update ce after the edge.
    task automatic tick(output logic acc);
        @(negedge clk);
        acc = sel_tready && tvalid;
        cap_d.push_back(sel_txd);
        cap_en.push_back(sel_en);
        cap_er.push_back(sel_er);
        if (sel_tready && !ce) tready_bad++;
        @(posedge clk);
        #1;
        ce = ce_toggle ? ~ce : 1'b1;
    endtask

    task automatic idle_ticks(input int n);
        logic acc;
        repeat (n) tick(acc);
    endtask

    task automatic clear_all();
        cap_d.delete(); cap_en.delete(); cap_er.delete();
        exp_q.delete(); pay_q.delete(); last_q.delete(); user_q.delete();
        tready_bad = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00;
        idle_ticks(2);
        rst = 1'b0;
        clear_all();
    endtask

    task automatic push_frame(input int n, input int base, input int step, input bit last_f, input bit user_f);
        for (int i = 0; i < n; i++) begin
            pay_q.push_back(8'(base + i * step));
            last_q.push_back(last_f && (i == n - 1));
            user_q.push_back(user_f && (i == n - 1));
        end
    endtask

    task automatic drive_q(input string name);
        int   i, guard;
        logic acc;
        i = 0; guard = 0;
        while (i < pay_q.size() && guard < 5000) begin
            tvalid = 1'b1; tdata = pay_q[i]; tlast = last_q[i]; tuser = user_q[i];
            tick(acc);
            if (acc) i++;
            guard++;
        end
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00;
        checks++;
        if (i !== pay_q.size()) begin
            errors++;
            $display("FAIL %s_drive accepted %0d expected %0d", name, i, pay_q.size());
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (k < 600 && sel_busy) begin
            idle_ticks(1);
            k++;
        end
        idle_ticks(2);
        checks++;
        if (sel_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle busy %b expected 0", name, sel_busy);
        end
    endtask

    task automatic exp_frame(input int s, input int n, input bit pad, input bit fcs);
        logic [31:0] c;
        int          tot;
        c = 32'hFFFFFFFF;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pay_q[s + i]);
            c = crc_upd(c, pay_q[s + i]);
        end
        tot = n;
        if (pad) begin
            while (tot < 60) begin
                exp_q.push_back(8'h00);
                c = crc_upd(c, 8'h00);
                tot++;
            end
        end
        if (fcs) begin
            c = ~c;
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(c[7:0]);
                c = c >> 8;
            end
        end
    endtask

    // Bytes seen while tx_en=1 must equal exp_q, each repeated 'hold' clocks.
    task automatic check_frame(input string name, input int hold);
        logic [7:0] got[$];
        int         idx;
        for (int i = 0; i < cap_d.size(); i++) if (cap_en[i] === 1'b1) got.push_back(cap_d[i]);
        checks++;
        if (got.size() !== exp_q.size() * hold) begin
            errors++;
            $display("FAIL %s_len tx_en clocks %0d expected %0d", name, got.size(), exp_q.size() * hold);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            for (int h = 0; h < hold; h++) begin
                idx = k * hold + h;
                if (idx < got.size()) begin
                    checks++;
                    if (got[idx] !== exp_q[k]) begin
                        errors++;
                        $display("FAIL %s_byte[%0d] got %h expected %h", name, idx, got[idx], exp_q[k]);
                    end
                end
            end
        end
    endtask

    task automatic check_er(input string name, input int exp_cnt, input int exp_pos);
        int   cnt, pos, epos;
        logic nxt_en;
        cnt = 0; pos = -1; epos = 0; nxt_en = 1'bx;
        for (int i = 0; i < cap_er.size(); i++) begin
            if (cap_er[i] === 1'b1) begin
                cnt++;
                if (pos < 0) begin
                    pos = epos;
                    nxt_en = (i + 1 < cap_en.size()) ? cap_en[i + 1] : 1'bx;
                end
            end
            if (cap_en[i] === 1'b1) epos++;
        end
        checks++;
        if (cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_er_count got %0d expected %0d", name, cnt, exp_cnt);
        end
        if (exp_cnt > 0) begin
            checks++;
            if (pos !== exp_pos) begin
                errors++;
                $display("FAIL %s_er_slot got %0d expected %0d", name, pos, exp_pos);
            end
            checks++;
            if (nxt_en !== 1'b0) begin
                errors++;
                $display("FAIL %s_en_after_er got %b expected 0", name, nxt_en);
            end
        end
    endtask

    task automatic check_cnt(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_ticks(2);
        check_cnt("reset_txd", CW'(txd_a), '0);
        check_cnt("reset_tx_en", CW'(tx_en_a), '0);
        check_cnt("reset_tx_er", CW'(tx_er_a), '0);
        check_cnt("reset_tready", CW'(tready_a), '0);
        check_cnt("reset_busy", CW'(busy_a), '0);
        check_cnt("reset_frame_cnt", fc_a, '0);
        check_cnt("reset_err_cnt", ec_a, '0);
        rst = 1'b0;
        clear_all();
    endtask

    task automatic test_crc_nopad();
        use_np = 1'b1;
        do_reset();
        push_frame(9, 8'h31, 1, 1'b1, 1'b0);
        drive_q("crc");
        wait_idle("crc");
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
        exp_q.push_back(8'h26); exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        check_frame("crc", 1);
        check_er("crc", 0, 0);
        check_cnt("crc_frame_cnt", sel_fc, CW'(1));
        check_cnt("crc_err_cnt", sel_ec, CW'(0));
        use_np = 1'b0;
    endtask

    task automatic test_pad();
        do_reset();
        push_frame(1, 8'hAA, 0, 1'b1, 1'b0);
        drive_q("pad");
        wait_idle("pad");
        exp_frame(0, 1, 1'b1, 1'b1);
        check_frame("pad", 1);
        check_er("pad", 0, 0);
        check_cnt("pad_frame_cnt", sel_fc, CW'(1));
    endtask

    task automatic test_ce_pacing();
        do_reset();
        push_frame(64, 8'h10, 3, 1'b1, 1'b0);
        ce_toggle = 1'b1;
        drive_q("pace");
        wait_idle("pace");
        ce_toggle = 1'b0;
        idle_ticks(1);
        exp_frame(0, 64, 1'b1, 1'b1);
        check_frame("pace", 2);
        check_cnt("pace_tready_without_ce", CW'(tready_bad), '0);
        check_cnt("pace_frame_cnt", sel_fc, CW'(1));
    endtask

    task automatic test_underflow();
        do_reset();
        push_frame(10, 8'h40, 1, 1'b0, 1'b0);
        exp_frame(0, 10, 1'b0, 1'b0);
        exp_q.push_back(8'h00);
        drive_q("uf_head");
        idle_ticks(3);
        pay_q.delete(); last_q.delete(); user_q.delete();
        push_frame(10, 8'h4A, 1, 1'b1, 1'b0);
        drive_q("uf_tail");
        wait_idle("underflow");
        check_frame("underflow", 1);
        check_er("underflow", 1, 18);
        check_cnt("underflow_err_cnt", sel_ec, CW'(1));
        check_cnt("underflow_frame_cnt", sel_fc, CW'(0));
    endtask

    task automatic test_back_to_back();
        int         i, gap, nz;
        logic [7:0] start_byte;
        do_reset();
        push_frame(4, 8'hC0, 1, 1'b1, 1'b0);
        push_frame(4, 8'hE0, 1, 1'b1, 1'b0);
        drive_q("b2b");
        wait_idle("b2b");
        exp_frame(0, 4, 1'b1, 1'b1);
        exp_frame(4, 4, 1'b1, 1'b1);
        check_frame("b2b", 1);
        i = 0; gap = 0; nz = 0;
        while (i < cap_en.size() && cap_en[i] !== 1'b1) i++;
        while (i < cap_en.size() && cap_en[i] === 1'b1) i++;
        while (i < cap_en.size() && cap_en[i] !== 1'b1) begin
            if (cap_d[i] !== 8'h00) nz++;
            gap++;
            i++;
        end
        start_byte = (i < cap_d.size()) ? cap_d[i] : 8'hxx;
        check_cnt("b2b_ifg_slots", CW'(gap), CW'(12));
        check_cnt("b2b_ifg_txd_nonzero", CW'(nz), CW'(0));
        check_cnt("b2b_second_start", CW'(start_byte), CW'(8'h55));
        check_cnt("b2b_frame_cnt", sel_fc, CW'(2));
    endtask

    task automatic test_abort();
        do_reset();
        push_frame(30, 8'h80, 1, 1'b1, 1'b1);
        drive_q("abort");
        wait_idle("abort");
        exp_frame(0, 30, 1'b0, 1'b0);
        check_frame("abort", 1);
        check_er("abort", 1, 37);
        check_cnt("abort_err_cnt", sel_ec, CW'(1));
        check_cnt("abort_frame_cnt", sel_fc, CW'(0));
    endtask

    task automatic test_reset_mid();
        logic acc;
        do_reset();
        push_frame(4, 8'h05, 1, 1'b1, 1'b0);
        drive_q("rmid");
        wait_idle("rmid");
        check_cnt("rmid_frame_cnt_before", sel_fc, CW'(1));
        tvalid = 1'b1; tdata = 8'h77; tlast = 1'b0; tuser = 1'b0;
        idle_ticks(12);
        check_cnt("rmid_in_data_tx_en", CW'(sel_en), CW'(1));
        rst = 1'b1;
        tick(acc);
        rst = 1'b0; tvalid = 1'b0;
        check_cnt("rmid_txd", CW'(sel_txd), '0);
        check_cnt("rmid_tx_en", CW'(sel_en), '0);
        check_cnt("rmid_tx_er", CW'(sel_er), '0);
        check_cnt("rmid_busy", CW'(sel_busy), '0);
        check_cnt("rmid_tready", CW'(sel_tready), '0);
        check_cnt("rmid_frame_cnt", sel_fc, '0);
        check_cnt("rmid_err_cnt", sel_ec, '0);
    endtask

    initial begin
        checks = 0; errors = 0; tready_bad = 0;
        rst = 1'b1; ce = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00;
        use_np = 1'b0; ce_toggle = 1'b0;
        test_reset();
        test_crc_nopad();
        test_pad();
        test_ce_pacing();
        test_underflow();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
